// File: rtl/obstacle_avoid_fsm.sv
// -----------------------------------------------------------------------------
// obstacle_avoid_fsm
//
// Purpose:
//   Timed obstacle-avoidance state machine for the rover. Consumes the
//   filtered front/back IR obstacle vectors from the proximity sensor stage
//   and drives left/right motor enable and direction commands towards the
//   PWM/H-bridge driver. Sequence: cruise forward, brake, reverse, turn in
//   place, retry; halt after too many consecutive blocked turns.
//
// Ports:
//   clock           in   system clock
//   reset           in   synchronous, active-high reset
//   enable          in   autonomous drive enable (0 forces IDLE next edge)
//   IPsensFront_in  in   [3:0] front obstacles, [3:2] left half, [1:0] right
//   IPsensBack_in   in   [3:0] rear obstacles
//   motor_en_l/r    out  motor enables
//   motor_dir_l/r   out  motor directions, 1 = forward
//   state_out       out  [2:0] current state code
//   busy            out  high in BRAKE / REVERSE / TURN_L / TURN_R
//
// Optional feature (macro AVOID_STATS_EN):
//   obstacle_count  out  [15:0] BRAKE entries, saturating at 16'hFFFF
//   halt_flag       out  set on HALT entry, sticky until reset
//
// Outputs are a pure decode of the state register.
// -----------------------------------------------------------------------------
module obstacle_avoid_fsm #(
    parameter int TICK_DIV   = 100000,
    parameter int STOP_MS    = 50,
    parameter int REVERSE_MS = 300,
    parameter int TURN_MS    = 400,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] IPsensFront_in,
    input  logic [3:0] IPsensBack_in,
    output logic       motor_en_l,
    output logic       motor_en_r,
    output logic       motor_dir_l,
    output logic       motor_dir_r,
    output logic [2:0] state_out,
    output logic       busy
`ifdef AVOID_STATS_EN
    ,
    output logic [15:0] obstacle_count,
    output logic        halt_flag
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FWD    = 3'd1,
        S_BRAKE  = 3'd2,
        S_REV    = 3'd3,
        S_TURN_L = 3'd4,
        S_TURN_R = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam int MS_MAX_A = (STOP_MS > REVERSE_MS) ? STOP_MS : REVERSE_MS;
    localparam int MS_MAX   = (MS_MAX_A > TURN_MS) ? MS_MAX_A : TURN_MS;
    localparam int PRE_W    = (TICK_DIV > 1)  ? $clog2(TICK_DIV)  : 1;
    localparam int MS_W     = (MS_MAX > 1)    ? $clog2(MS_MAX)    : 1;
    localparam int RTY_W    = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]  STOP_LAST  = MS_W'(STOP_MS - 1);
    localparam logic [MS_W-1:0]  REV_LAST   = MS_W'(REVERSE_MS - 1);
    localparam logic [MS_W-1:0]  TURN_LAST  = MS_W'(TURN_MS - 1);
    localparam logic [RTY_W-1:0] RETRY_LAST = RTY_W'(MAX_RETRY - 1);

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [MS_W-1:0]    ms_q, ms_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               alt_q, alt_d;
    logic [3:0]         latch_q, latch_d;

    logic               timed;
    logic               expire;
    logic [MS_W-1:0]    dur_last;
    logic               both_halves;
    state_t             turn_sel;

    // Turn away from the side the obstacle was seen on; when both halves
    // were blocked, alternate direction so repeated retries explore both.
    function automatic state_t pick_turn(input logic [3:0] latch, input logic alt);
        logic left_hit;
        logic right_hit;
        left_hit  = |latch[3:2];
        right_hit = |latch[1:0];
        if (left_hit && right_hit) begin
            pick_turn = alt ? S_TURN_R : S_TURN_L;
        end else if (left_hit) begin
            pick_turn = S_TURN_R;
        end else begin
            pick_turn = S_TURN_L;
        end
    endfunction

    // Duration timer: prescaler counts clock cycles per ms tick, ms counter
    // counts ticks. Expiry is flagged on the last cycle of the state.
    always_comb begin
        timed    = 1'b0;
        dur_last = '0;
        case (state_q)
            S_BRAKE:            begin timed = 1'b1; dur_last = STOP_LAST; end
            S_REV:              begin timed = 1'b1; dur_last = REV_LAST;  end
            S_TURN_L, S_TURN_R: begin timed = 1'b1; dur_last = TURN_LAST; end
            default:            begin timed = 1'b0; dur_last = '0;        end
        endcase
        expire = timed && (pre_q == PRE_LAST) && (ms_q == dur_last);
    end

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        alt_d       = alt_q;
        latch_d     = latch_q;
        both_halves = (|latch_q[3:2]) && (|latch_q[1:0]);
        turn_sel    = pick_turn(latch_q, alt_q);

        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FWD;
                    retry_d = '0;
                end
                S_FWD: begin
                    if (|IPsensFront_in) begin
                        state_d = S_BRAKE;
                        latch_d = IPsensFront_in;
                    end
                end
                S_BRAKE: begin
                    if (expire) begin
                        if (IPsensBack_in == 4'b0000) begin
                            state_d = S_REV;
                        end else begin
                            state_d = turn_sel;
                            if (both_halves) alt_d = ~alt_q;
                        end
                    end
                end
                S_REV: begin
                    // A rear obstacle aborts the reverse immediately.
                    if ((|IPsensBack_in) || expire) begin
                        state_d = turn_sel;
                        if (both_halves) alt_d = ~alt_q;
                    end
                end
                S_TURN_L, S_TURN_R: begin
                    if (expire) begin
                        if (IPsensFront_in == 4'b0000) begin
                            state_d = S_FWD;
                            retry_d = '0;
                        end else if (retry_q == RETRY_LAST) begin
                            state_d = S_HALT;
                        end else begin
                            state_d = S_BRAKE;
                            retry_d = retry_q + RTY_W'(1);
                            latch_d = IPsensFront_in;
                        end
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Timer restarts on every state change and idles outside timed states.
    always_comb begin
        pre_d = pre_q;
        ms_d  = ms_q;
        if ((state_d != state_q) || !timed) begin
            pre_d = '0;
            ms_d  = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            ms_d  = ms_q + MS_W'(1);
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            ms_q    <= '0;
            retry_q <= '0;
            alt_q   <= 1'b0;
            latch_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            retry_q <= retry_d;
            alt_q   <= alt_d;
            latch_q <= latch_d;
        end
    end

`ifdef AVOID_STATS_EN
    logic [15:0] obstacle_count_q, obstacle_count_d;
    logic        halt_flag_q, halt_flag_d;

    always_comb begin
        obstacle_count_d = obstacle_count_q;
        halt_flag_d      = halt_flag_q;
        if ((state_d == S_BRAKE) && (state_q != S_BRAKE) && (obstacle_count_q != 16'hFFFF)) begin
            obstacle_count_d = obstacle_count_q + 16'd1;
        end
        if ((state_d == S_HALT) && (state_q != S_HALT)) begin
            halt_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            obstacle_count_q <= 16'd0;
            halt_flag_q      <= 1'b0;
        end else begin
            obstacle_count_q <= obstacle_count_d;
            halt_flag_q      <= halt_flag_d;
        end
    end

    assign obstacle_count = obstacle_count_q;
    assign halt_flag      = halt_flag_q;
`endif

    // Output decode of the registered state.
    always_comb begin
        motor_en_l  = 1'b0;
        motor_en_r  = 1'b0;
        motor_dir_l = 1'b1;
        motor_dir_r = 1'b1;
        busy        = 1'b0;
        case (state_q)
            S_FWD: begin
                motor_en_l = 1'b1;
                motor_en_r = 1'b1;
            end
            S_BRAKE: begin
                busy = 1'b1;
            end
            S_REV: begin
                motor_en_l  = 1'b1;
                motor_en_r  = 1'b1;
                motor_dir_l = 1'b0;
                motor_dir_r = 1'b0;
                busy        = 1'b1;
            end
            S_TURN_L: begin
                motor_en_l  = 1'b1;
                motor_en_r  = 1'b1;
                motor_dir_l = 1'b0;
                busy        = 1'b1;
            end
            S_TURN_R: begin
                motor_en_l  = 1'b1;
                motor_en_r  = 1'b1;
                motor_dir_r = 1'b0;
                busy        = 1'b1;
            end
            default: begin
                motor_en_l = 1'b0;
                motor_en_r = 1'b0;
            end
        endcase
    end

    assign state_out = state_q;

endmodule
